// File: rtl/branch_cond_unit_if.sv
// Bus bundle between the control unit and branch_cond_unit.
// The control unit uses the master modport and the condition FF uses the slave modport.
// Optional feature macro: BCU_TAKEN_COUNT_EN. When it is defined, the bundle
// also carries the taken counter.
interface branch_cond_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);

  // Strobes and operands driven by the control unit / datapath
  logic              CONin;
  logic              Ain;
  logic [3:0]        IRbits;
  logic [DATA_W-1:0] busMuxOut;

  // Results returned by the condition unit
  logic              q;
  logic              q_valid;
  logic              a_valid;
  logic              cond_err;
`ifdef BCU_TAKEN_COUNT_EN
  logic [CNT_W-1:0]  taken_count;
`endif

  // Reject nonsensical widths at elaboration time
  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("branch_cond_unit_if: DATA_W and CNT_W must be >= 1");
  end

  modport master (
    output CONin,
    output Ain,
    output IRbits,
    output busMuxOut,
    input  q,
    input  q_valid,
    input  a_valid,
`ifdef BCU_TAKEN_COUNT_EN
    input  taken_count,
`endif
    input  cond_err
  );

  modport slave (
    input  CONin,
    input  Ain,
    input  IRbits,
    input  busMuxOut,
    output q,
    output q_valid,
    output a_valid,
`ifdef BCU_TAKEN_COUNT_EN
    output taken_count,
`endif
    output cond_err
  );

endinterface

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: branch-condition flip-flop for the multi-cycle bus CPU.
// It evaluates a 4-bit condition code against busMuxOut and registers the
// taken/not-taken result into q.
// Two-operand codes compare a previously latched operand A with busMuxOut,
// which acts as operand B.
// Optional feature macro: BCU_TAKEN_COUNT_EN. It adds a saturating taken
// counter, taken_count.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int ZERO_W = 32,
  parameter bit KEEP_A = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,   // asynchronous, active-low
  branch_cond_unit_if.slave  bus
);

  // Condition code map
  localparam logic [3:0] CC_ZERO  = 4'b0000;
  localparam logic [3:0] CC_NZERO = 4'b0001;
  localparam logic [3:0] CC_GEZ   = 4'b0010;
  localparam logic [3:0] CC_LTZ   = 4'b0011;
  localparam logic [3:0] CC_EQ    = 4'b0100;
  localparam logic [3:0] CC_NE    = 4'b0101;
  localparam logic [3:0] CC_LT_S  = 4'b0110;
  localparam logic [3:0] CC_GE_S  = 4'b0111;
  localparam logic [3:0] CC_LT_U  = 4'b1000;
  localparam logic [3:0] CC_GE_U  = 4'b1001;
  localparam logic [3:0] CC_GT_S  = 4'b1010;
  localparam logic [3:0] CC_LE_S  = 4'b1011;
  localparam logic [3:0] CC_ALWAYS = 4'b1100;
  localparam logic [3:0] CC_NEVER  = 4'b1101;

  // The zero test looks at a slice of the bus, so that slice cannot be wider than the bus
  if (ZERO_W < 1 || ZERO_W > DATA_W || CNT_W < 1) begin : g_bad_param
    $error("branch_cond_unit: need 1 <= ZERO_W <= DATA_W and CNT_W >= 1");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } a_state_t;

  a_state_t          state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              take_q, take_d;
  logic              q_valid_q, q_valid_d;
  logic              cond_err_q, cond_err_d;

  // Decoded condition information
  logic              a_held;
  logic              two_op;
  logic              reserved_cc;
  logic              bus_zero;
  logic              bus_neg;
  logic              a_eq_b;
  logic              a_lt_b_s;
  logic              a_lt_b_u;
  logic              raw_result;
  logic              eval_result;
  logic              eval_err;

  assign a_held = (state_q == HELD);

  // Classify the condition code and form the operand flags for the comparison.
  // The comparisons use the full operand width. In the same cycle that A is being
  // reloaded, the old A is used.
  always_comb begin
    two_op      = (bus.IRbits >= CC_EQ) && (bus.IRbits <= CC_LE_S);
    reserved_cc = (bus.IRbits[3:1] == 3'b111);
    bus_zero    = (bus.busMuxOut[ZERO_W-1:0] == '0);
    bus_neg     = bus.busMuxOut[DATA_W-1];
    a_eq_b      = (a_q == bus.busMuxOut);
    a_lt_b_s    = ($signed(a_q) < $signed(bus.busMuxOut));
    a_lt_b_u    = (a_q < bus.busMuxOut);
  end

  // Select the raw result for the code, then mask it if the code is invalid in this context
  always_comb begin
    raw_result = 1'b0;
    unique case (bus.IRbits)
      CC_ZERO:   raw_result = bus_zero;
      CC_NZERO:  raw_result = !bus_zero;
      CC_GEZ:    raw_result = !bus_neg;
      CC_LTZ:    raw_result = bus_neg;
      CC_EQ:     raw_result = a_eq_b;
      CC_NE:     raw_result = !a_eq_b;
      CC_LT_S:   raw_result = a_lt_b_s;
      CC_GE_S:   raw_result = !a_lt_b_s;
      CC_LT_U:   raw_result = a_lt_b_u;
      CC_GE_U:   raw_result = !a_lt_b_u;
      CC_GT_S:   raw_result = !a_lt_b_s && !a_eq_b;
      CC_LE_S:   raw_result = a_lt_b_s || a_eq_b;
      CC_ALWAYS: raw_result = 1'b1;
      CC_NEVER:  raw_result = 1'b0;
      default:   raw_result = 1'b0;   // reserved codes 1110/1111
    endcase

    eval_err    = reserved_cc || (two_op && !a_held);
    eval_result = eval_err ? 1'b0 : raw_result;
  end

  // Next-state logic for the operand-A holder and the result registers.
  // Ain always wins and leaves the FSM in HELD. A compare consumes A only when
  // no reload happens in the same cycle.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    take_d     = take_q;
    q_valid_d  = q_valid_q;
    cond_err_d = cond_err_q;

    unique case (state_q)
      EMPTY: begin
        if (bus.Ain) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (bus.Ain) begin
          state_d = HELD;
        end else if (bus.CONin && two_op && !KEEP_A) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (bus.Ain) begin
      a_d = bus.busMuxOut;
    end

    if (bus.CONin) begin
      take_d     = eval_result;
      cond_err_d = eval_err;
      q_valid_d  = 1'b1;
    end else if (bus.Ain) begin
      // Re-arming operand A makes any earlier result stale
      q_valid_d  = 1'b0;
    end
  end

  // State and result registers. An asynchronous reset discards any held operand.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      a_q        <= '0;
      take_q     <= 1'b0;
      q_valid_q  <= 1'b0;
      cond_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      take_q     <= take_d;
      q_valid_q  <= q_valid_d;
      cond_err_q <= cond_err_d;
    end
  end

  assign bus.q        = take_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.a_valid  = a_held;
  assign bus.cond_err = cond_err_q;

`ifdef BCU_TAKEN_COUNT_EN
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  // Count taken evaluations and stick at the all-ones value
  always_comb begin
    taken_count_d = taken_count_q;
    if (bus.CONin && eval_result && (taken_count_q != {CNT_W{1'b1}})) begin
      taken_count_d = taken_count_q + 1'b1;
    end
  end

  // Taken counter register. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_count_q <= '0;
    end else begin
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed testbench for branch_cond_unit. The expected values are computed by hand from the condition table.
// If BCU_TAKEN_COUNT_EN is defined, the bench also checks counter saturation with CNT_W=2.
module tb_branch_cond_unit;

`ifdef BCU_TAKEN_COUNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  branch_cond_unit_if #(.DATA_W(32), .CNT_W(TB_CNT_W)) bif ();

  branch_cond_unit #(
    .DATA_W(32),
    .ZERO_W(32),
    .KEEP_A(1'b0),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  // Drive one clock cycle. Inputs are applied here, and outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic ain, input logic conin, input logic [3:0] ir,
                       input logic [31:0] data);
    bif.Ain       = ain;
    bif.CONin     = conin;
    bif.IRbits    = ir;
    bif.busMuxOut = data;
    @(posedge clk);
    #1;
    bif.Ain   = 1'b0;
    bif.CONin = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic exp_q, input logic exp_qv,
                              input logic exp_av, input logic exp_err);
    check_value({tag, ".q"},        32'(bif.q),        32'(exp_q));
    check_value({tag, ".q_valid"},  32'(bif.q_valid),  32'(exp_qv));
    check_value({tag, ".a_valid"},  32'(bif.a_valid),  32'(exp_av));
    check_value({tag, ".cond_err"}, 32'(bif.cond_err), 32'(exp_err));
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b0;
    bif.Ain       = 1'b0;
    bif.CONin     = 1'b0;
    bif.IRbits    = 4'h0;
    bif.busMuxOut = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_result("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BCU_TAKEN_COUNT_EN
    check_value("reset.taken_count", 32'(bif.taken_count), 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Tests on a single operand
    cycle(1'b0, 1'b1, 4'b0000, 32'h0000_0000);
    check_result("zero", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0001, 32'h0000_0100);
    check_result("nonzero", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0011, 32'h8000_0000);
    check_result("ltz", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0010, 32'h8000_0000);
    check_result("gez", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0011, 32'h8000_0000);
    check_result("hold", 1'b0, 1'b1, 1'b0, 1'b0);

    // Signed vs unsigned compare with A = -1 and B = 1
    cycle(1'b1, 1'b0, 4'b0000, 32'hFFFF_FFFF);
    check_result("loadA", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'b0110, 32'h0000_0001);
    check_result("lt_s", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'b0000, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 4'b1000, 32'h0000_0001);
    check_result("lt_u", 1'b0, 1'b1, 1'b0, 1'b0);

    // Signed greater-than with A = 3 and B = -2
    cycle(1'b1, 1'b0, 4'b0000, 32'h0000_0003);
    cycle(1'b0, 1'b1, 4'b1010, 32'hFFFF_FFFE);
    check_result("gt_s", 1'b1, 1'b1, 1'b0, 1'b0);

    // Ain and CONin asserted together: the compare uses the old A, then A reloads
    cycle(1'b1, 1'b0, 4'b0000, 32'h0000_0005);
    cycle(1'b1, 1'b1, 4'b0100, 32'h0000_0005);
    check_result("simul_eq", 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'b0101, 32'h0000_0007);
    check_result("ne_after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Error paths
    cycle(1'b0, 1'b1, 4'b0100, 32'h0000_0007);
    check_result("noA_err", 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'b1110, 32'h0000_0000);
    check_result("reserved", 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'b1100, 32'h0000_0000);
    check_result("always", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b1101, 32'h0000_0000);
    check_result("never", 1'b0, 1'b1, 1'b0, 1'b0);

    // Ain and CONin asserted together while EMPTY: the compare flags an error, and A still loads
    cycle(1'b1, 1'b1, 4'b0100, 32'h0000_0009);
    check_result("simul_empty", 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'b0100, 32'h0000_0009);
    check_result("eq_loaded", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset applied between clock edges
    cycle(1'b1, 1'b0, 4'b0000, 32'h0000_0001);
    cycle(1'b0, 1'b1, 4'b1100, 32'h0000_0000);
    check_result("pre_reset", 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_result("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

`ifdef BCU_TAKEN_COUNT_EN
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 4'b1100, 32'h0000_0000);
    end
    check_value("taken_sat", 32'(bif.taken_count), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so that the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Parametrised branch-condition flip-flop for the multi-cycle bus CPU. Successor to the 2-bit zero/sign condition FF.
- Evaluates a 4-bit condition code and registers the taken/not-taken result `q` for the control unit.
- Covers the legacy single-operand tests on busMuxOut (zero, nonzero, >=0, <0).
- Adds two-operand compares: operand A is latched from the bus in an earlier cycle, and busMuxOut is operand B in the evaluate cycle.

Parameters:
- DATA_W, 32: bus/operand width.
- ZERO_W, 32: number of low bits of busMuxOut used by the zero/nonzero tests. Must be <= DATA_W.
- KEEP_A, 0: 1 = operand A is retained after a compare. 0 = operand A is consumed by the compare.
- CNT_W, 8: width of the taken counter (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- CONin  input  1  evaluate strobe; condition result is registered into q.
- Ain  input  1  latch busMuxOut into the operand-A register.
- IRbits  input  4  condition code from IR.
- busMuxOut  input  DATA_W  datapath bus.
- q  output  1  registered condition result.
- q_valid  output  1  q holds the result of a completed evaluation.
- a_valid  output  1  operand A is held.
- cond_err  output  1  last evaluation used a reserved code, or a two-operand code without A held.
- taken_count  output  CNT_W  saturating taken counter (present only with BCU_TAKEN_COUNT_EN).

Behaviour:
- Reset (reset=0, asynchronous): q=0, q_valid=0, a_valid=0, cond_err=0, A register=0, taken_count=0, FSM=EMPTY.
- FSM states: EMPTY (no A held) and HELD (A held). a_valid=1 exactly in HELD.
  - EMPTY: Ain=1 -> HELD with A<=busMuxOut.
  - HELD: Ain=1 -> stay HELD with A<=busMuxOut (overwrite).
  - HELD: CONin=1 with a two-operand code and Ain=0 -> EMPTY if KEEP_A=0, HELD if KEEP_A=1.
  - HELD: any other case -> stay HELD.
- Condition codes. Z = (busMuxOut[ZERO_W-1:0]==0). B = busMuxOut.
  - 0000: Z
  - 0001: !Z
  - 0010: B[DATA_W-1]==0
  - 0011: B[DATA_W-1]==1
  - 0100: A==B
  - 0101: A!=B
  - 0110: A<B, signed
  - 0111: A>=B, signed
  - 1000: A<B, unsigned
  - 1001: A>=B, unsigned
  - 1010: A>B, signed
  - 1011: A<=B, signed
  - 1100: 1 (always)
  - 1101: 0 (never)
  - 1110, 1111: reserved, result 0, cond_err=1.
- Two-operand codes (0100-1011) evaluated while a_valid=0: result 0, cond_err=1.
- Latency: on the rising edge with CONin=1, q, q_valid=1 and cond_err update together. The values are visible the following cycle.
- Holding: with CONin=0, q and cond_err hold their values.
- q_valid clear: cleared on any edge with Ain=1 and CONin=0, since the pending compare is being re-armed.
- Simultaneous Ain and CONin: evaluation uses the previously held A (old register value). A then loads busMuxOut. q_valid=1 and the FSM ends in HELD. If EMPTY, a two-operand code flags cond_err and A still loads.
- Compare arithmetic: full DATA_W width, no truncation. Signed compares treat bit DATA_W-1 as the sign bit.
- Reset mid-operation: everything returns to reset values immediately. A held A is discarded.

Optional Feature:
- Macro: BCU_TAKEN_COUNT_EN.
- With the macro defined:
  - taken_count increments on each edge with CONin=1 and a result of 1.
  - It saturates at 2^CNT_W-1.
  - Cleared by reset only.
- Without the macro: the port and counter are absent, and all other behaviour is unchanged.

Test Plan:
- Zero tests: reset low then high; busMuxOut=0, IRbits=0000, CONin pulse -> next cycle q=1, q_valid=1, cond_err=0. Repeat with busMuxOut=32'h00000100, IRbits=0001 -> q=1.
- Sign tests: busMuxOut=32'h80000000. IRbits=0011 -> q=1. IRbits=0010 -> q=0.
- Signed vs unsigned compare: Ain with bus=32'hFFFFFFFF (a_valid=1), then CONin with bus=1.
  - IRbits=0110 -> q=1, a_valid=0.
  - Reload A the same way; IRbits=1000 -> q=0.
- Simultaneous strobe: A=5 held; Ain=CONin=1, bus=5, IRbits=0100 -> q=1 (old A==5), a_valid=1, A=5. Next CONin, bus=7, IRbits=0101 -> q=1.
- Error paths: a_valid=0, IRbits=0100, CONin -> q=0, cond_err=1. IRbits=1110 -> q=0, cond_err=1. IRbits=1100 -> q=1, cond_err=0.
- Async reset mid-operation: A held, q=1; assert reset=0 between clock edges -> q=0, q_valid=0, a_valid=0 without a clock edge. With BCU_TAKEN_COUNT_EN and CNT_W=2: 5 taken evaluations -> taken_count=3.
